cycle_bcd_display: RTL and testbench

- Downstream consumer of the image-processing wrapper's `done` / `total_cycles` outputs.
- On each completed run, latches the cycle count and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives six active-low 7-segment HEX digits on the DE1-SoC, with BCD and status outputs alongside.
- Replaces the raw LED bit-slice view of the cycle counter at board top level.

---
 rtl/cycle_bcd_display.sv | 165 ++++++++++++++++
 tb/tb_cycle_bcd_display.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cycle_bcd_display.sv
// Latches a completed run's cycle count, converts it to BCD with a serial double-dabble engine
// and drives active-low 7-segment digits with leading-zero blanking.
module cycle_bcd_display #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [CNT_W-1:0]      cycles_i,
  output logic [DIGITS*4-1:0]   bcd_o,
  output logic [DIGITS*7-1:0]   hex_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  ovf_o
);

  localparam int unsigned BcdW  = DIGITS * 4;
  localparam int unsigned HexW  = DIGITS * 7;
  localparam int unsigned IterW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] Limit = pow10(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

  state_e             r_state, w_state_d;
  logic               r_done_prev;
  logic [CNT_W-1:0]   r_bin, w_bin_d;
  logic [BcdW-1:0]    r_acc, w_acc_d, w_acc_adj;
  logic [IterW-1:0]   r_iter, w_iter_d;
  logic [BcdW-1:0]    r_bcd, w_bcd_d;
  logic [HexW-1:0]    r_hex, w_hex_d, w_hex;
  logic               r_valid, w_valid_d;
  logic               r_busy, w_busy_d;
  logic               r_ovf, w_ovf_d;
  logic               w_rise;
  logic               w_lead;
  logic [3:0]         w_nib;

  assign w_rise = done_i & ~r_done_prev;

  // Nibble-local add-3 ahead of the shift; no carry crosses a digit boundary.
  always_comb begin
    w_acc_adj = r_acc;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_acc_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the most significant digit so leading zeros blank until the first non-zero.
  always_comb begin
    w_hex  = '1;
    w_lead = 1'b1;
    w_nib  = 4'd0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      w_nib = r_acc[4*k +: 4];
      if (w_nib != 4'd0) w_lead = 1'b0;
      if (k != 0 && w_lead) w_hex[7*k +: 7] = 7'h7F;
      else                  w_hex[7*k +: 7] = seg7(w_nib);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_bin_d   = r_bin;
    w_acc_d   = r_acc;
    w_iter_d  = r_iter;
    w_bcd_d   = r_bcd;
    w_hex_d   = r_hex;
    w_valid_d = r_valid;
    w_busy_d  = r_busy;
    w_ovf_d   = r_ovf;
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_bin_d   = cycles_i;
          w_acc_d   = '0;
          w_iter_d  = '0;
          w_busy_d  = 1'b1;
          w_valid_d = 1'b0;
          if (64'(cycles_i) >= Limit) begin
            w_ovf_d   = 1'b1;
            w_acc_d   = {DIGITS{4'h9}};
            w_state_d = StLoad;
          end else begin
            w_ovf_d   = 1'b0;
            w_state_d = StConv;
          end
        end
      end
      StConv: begin
        w_acc_d  = {w_acc_adj[BcdW-2:0], r_bin[CNT_W-1]};
        w_bin_d  = {r_bin[CNT_W-2:0], 1'b0};
        w_iter_d = r_iter + IterW'(1);
        if (r_iter == IterW'(CNT_W - 1)) w_state_d = StLoad;
      end
      StLoad: begin
        w_bcd_d   = r_acc;
        w_hex_d   = w_hex;
        w_valid_d = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_done_prev <= 1'b0;
      r_bin       <= '0;
      r_acc       <= '0;
      r_iter      <= '0;
      r_bcd       <= '0;
      r_hex       <= '1;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_done_prev <= done_i;
      r_bin       <= w_bin_d;
      r_acc       <= w_acc_d;
      r_iter      <= w_iter_d;
      r_bcd       <= w_bcd_d;
      r_hex       <= w_hex_d;
      r_valid     <= w_valid_d;
      r_busy      <= w_busy_d;
      r_ovf       <= w_ovf_d;
    end
  end

  assign bcd_o   = r_bcd;
  assign hex_o   = r_hex;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_cycle_bcd_display.sv
// Directed bench for cycle_bcd_display: reset, conversions, overflow boundary, busy/hold and
// mid-conversion reset, with hand-computed expected values.
module tb_cycle_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_i;
  logic [31:0] cycles_i;
  logic [23:0] bcd_o;
  logic [41:0] hex_o;
  logic        valid_o;
  logic        busy_o;
  logic        ovf_o;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] B = 7'h7F;

  cycle_bcd_display #(
    .CNT_W  (32),
    .DIGITS (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .done_i   (done_i),
    .cycles_i (cycles_i),
    .bcd_o    (bcd_o),
    .hex_o    (hex_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " hex"},   64'(hex_o),   64'({6{B}}));
    check({tag, " bcd"},   64'(bcd_o),   64'd0);
    check({tag, " valid"}, 64'(valid_o), 64'd0);
    check({tag, " busy"},  64'(busy_o),  64'd0);
    check({tag, " ovf"},   64'(ovf_o),   64'd0);
  endtask

  // Rise on done_i, wait for valid, compare latency/result, then drop done_i and confirm hold.
  task automatic run_conv(input string tag, input logic [31:0] val, input int exp_lat,
                          input logic [23:0] exp_bcd, input logic [41:0] exp_hex,
                          input logic exp_ovf);
    int lat;
    int busy_cnt;
    cycles_i = val;
    done_i   = 1'b1;
    tick();
    busy_cnt = busy_o ? 1 : 0;
    check({tag, " valid@E0"}, 64'(valid_o), 64'd0);
    lat = 0;
    while (!valid_o && lat < 100) begin
      tick();
      lat++;
      if (busy_o) busy_cnt++;
    end
    check({tag, " latency"},  64'(lat),      64'(exp_lat));
    check({tag, " busy_cnt"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " bcd"},      64'(bcd_o),    64'(exp_bcd));
    check({tag, " hex"},      64'(hex_o),    64'(exp_hex));
    check({tag, " ovf"},      64'(ovf_o),    64'(exp_ovf));
    done_i = 1'b0;
    tick();
    tick();
    check({tag, " hold valid"}, 64'(valid_o), 64'd1);
    check({tag, " hold bcd"},   64'(bcd_o),   64'(exp_bcd));
  endtask

  initial begin
    int lat;
    int busy_seen;
    rst      = 1'b1;
    done_i   = 1'b0;
    cycles_i = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check_reset_state("reset");

    run_conv("c123456", 32'd123456, 33, 24'h123456,
             {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0);
    run_conv("c0", 32'd0, 33, 24'h000000, {B, B, B, B, B, 7'h40}, 1'b0);
    run_conv("c907", 32'd907, 33, 24'h000907, {B, B, B, 7'h10, 7'h40, 7'h78}, 1'b0);
    run_conv("c999999", 32'd999999, 33, 24'h999999, {6{7'h10}}, 1'b0);
    run_conv("c1000000", 32'd1000000, 1, 24'h999999, {6{7'h10}}, 1'b1);

    // Capture 42; a second rise and a new count mid-conversion must be ignored.
    cycles_i = 32'd42;
    done_i   = 1'b1;
    tick();
    lat = 0;
    repeat (3) begin tick(); lat++; end
    done_i = 1'b0;
    tick();
    lat++;
    done_i   = 1'b1;
    cycles_i = 32'd77;
    tick();
    lat++;
    while (!valid_o && lat < 100) begin
      tick();
      lat++;
    end
    check("c42 latency", 64'(lat),   64'd33);
    check("c42 bcd",     64'(bcd_o), 64'h000042);
    check("c42 hex",     64'(hex_o), 64'({B, B, B, B, 7'h19, 7'h24}));
    check("c42 ovf",     64'(ovf_o), 64'd0);
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (busy_o) busy_seen++;
    end
    check("c42 single load", 64'(busy_seen), 64'd0);
    check("c42 still bcd",   64'(bcd_o),     64'h000042);
    done_i = 1'b0;
    tick();
    check("c42 fall valid", 64'(valid_o), 64'd1);

    run_conv("c77", 32'd77, 33, 24'h000077, {B, B, B, B, 7'h78, 7'h78}, 1'b0);

    // Reset at cycle 10 of a conversion aborts it.
    cycles_i = 32'd12345;
    done_i   = 1'b1;
    tick();
    repeat (9) tick();
    check("abort busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_state("abort");
    rst    = 1'b0;
    done_i = 1'b0;
    tick();
    check_reset_state("post-abort");
    run_conv("c5", 32'd5, 33, 24'h000005, {B, B, B, B, B, 7'h12}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
